instr_mem: RTL and testbench

INSTR_MEM -- requirements
Module: instr_mem

---
 rtl/instr_mem_pkg.sv | 15 +
 rtl/instr_bram.sv | 27 ++
 rtl/instr_mem.sv | 112 +++++++++++
 tb/tb_instr_mem.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the instruction memory loader/fetch block.
package instr_mem_pkg;

    // Loader progress: length header, payload words, loaded, rejected
    typedef enum logic [1:0] {
        RX_LEN  = 2'd0,
        RX_DATA = 2'd1,
        DONE    = 2'd2,
        ERR     = 2'd3
    } state_t;

    // RV32I "addi x0, x0, 0" returned whenever no loaded word applies
    localparam logic [31:0] DEFAULT_NOP = 32'h0000_0013;

endpackage

// File: rtl/instr_bram.sv
// Simple dual-port word RAM: one write port, one registered read port.
// No reset on storage or read register so it maps onto block RAM.
module instr_bram #(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Registered read port; read-during-write returns the old word
    always_ff @(posedge clk) begin
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/instr_mem.sv
// Instruction memory with a byte-stream program loader.
// Stream format: 4-byte little-endian word count N, then N little-endian
// words. Once loaded, the fetch port returns words with one-cycle latency;
// anything outside the loaded region reads back as RESET_NOP.
module instr_mem
    import instr_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] RESET_NOP   = DEFAULT_NOP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    input  logic [7:0]  load_byte,
    output logic        load_ready,
    output logic        load_done,
    output logic        load_err,
    input  logic [31:0] instr_addr,
    output logic [31:0] instr,
    output logic        instr_valid
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t          state;
    logic [1:0]      byte_cnt;
    logic [23:0]     asm_q;      // first three bytes of the word in flight
    logic [31:0]     n_words;
    logic [AW-1:0]   wr_ptr;

    logic            xfer;
    logic [31:0]     full_word;
    logic            we;
    logic [AW-1:0]   rd_idx;
    logic            rd_in_range;
    logic            rd_hit;
    logic            rd_valid;
    logic [31:0]     bram_q;
    logic            unused_addr_lsb;

    assign load_ready = (state == RX_LEN) || (state == RX_DATA);
    assign load_done  = (state == DONE);
    assign load_err   = (state == ERR);

    assign xfer      = load_valid && load_ready;
    // Bytes arrive LSB first, so the current byte completes the top lane
    assign full_word = {load_byte, asm_q};
    assign we        = xfer && (state == RX_DATA) && (byte_cnt == 2'd3);

    // Loader FSM and byte assembler (shared by the length header and data)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RX_LEN;
            byte_cnt <= 2'd0;
            asm_q    <= 24'd0;
            n_words  <= 32'd0;
            wr_ptr   <= '0;
        end else if (xfer) begin
            byte_cnt <= byte_cnt + 2'd1;
            asm_q    <= {load_byte, asm_q[23:8]};
            if (byte_cnt == 2'd3) begin
                case (state)
                    RX_LEN: begin
                        n_words <= full_word;
                        wr_ptr  <= '0;
                        if (full_word == 32'd0)
                            state <= DONE;
                        else if (full_word > 32'(DEPTH_WORDS))
                            state <= ERR;
                        else
                            state <= RX_DATA;
                    end
                    RX_DATA: begin
                        wr_ptr <= wr_ptr + 1'b1;
                        if (32'(wr_ptr) == n_words - 32'd1)
                            state <= DONE;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Fetch gating: the state seen at the sampling edge decides validity,
    // so the final load write is never bypassed into a same-cycle read.
    assign rd_idx          = instr_addr[AW+1:2];
    assign rd_in_range     = (instr_addr >> (AW + 2)) == 32'd0;
    assign rd_hit          = (state == DONE) && rd_in_range && (32'(rd_idx) < n_words);
    assign unused_addr_lsb = ^instr_addr[1:0];   // byte offset within a word is ignored

    // Registered validity alongside the RAM read register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_valid <= 1'b0;
        else     rd_valid <= rd_hit;
    end

    assign instr_valid = rd_valid;
    assign instr       = rd_valid ? bram_q : RESET_NOP;

    instr_bram #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_bram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr),
        .wdata (full_word),
        .raddr (rd_idx),
        .rdata (bram_q)
    );

endmodule

// File: tb/tb_instr_mem.sv
// Randomized bench for instr_mem against a byte-count based reference model.
module tb_instr_mem;

    localparam int          DEPTH = 4096;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_valid = 1'b0;
    logic [7:0]  load_byte = 8'h00;
    logic        load_ready, load_done, load_err;
    logic [31:0] instr_addr = 32'h0;
    logic [31:0] instr;
    logic        instr_valid;

    int vectors = 0;
    int miscompares = 0;
    bit rand_rd = 1'b0;

    always #5 clk = ~clk;

    instr_mem #(.DEPTH_WORDS(DEPTH), .RESET_NOP(NOP)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_byte   (load_byte),
        .load_ready  (load_ready),
        .load_done   (load_done),
        .load_err    (load_err),
        .instr_addr  (instr_addr),
        .instr       (instr),
        .instr_valid (instr_valid)
    );

    // Reference model: everything follows from the number of bytes
    // accepted since reset and the declared length.
    int          n_acc = 0;
    logic [31:0] m_len = 32'h0;
    logic [31:0] m_mem [DEPTH];
    logic [31:0] exp_instr = NOP;
    logic        exp_valid = 1'b0;

    function automatic bit m_err();
        return (n_acc >= 4) && (m_len > DEPTH);
    endfunction

    function automatic bit m_done();
        return (n_acc >= 4) && (m_len <= DEPTH) &&
               (longint'(n_acc) == 64'd4 + 64'd4 * longint'(m_len));
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            n_acc     = 0;
            m_len     = 32'h0;
            exp_valid = 1'b0;
            exp_instr = NOP;
        end else begin
            exp_valid = m_done() && (longint'(instr_addr) < 64'd4 * DEPTH) &&
                        ((instr_addr >> 2) < m_len);
            if (exp_valid) exp_instr = m_mem[instr_addr >> 2];
            else           exp_instr = NOP;
            if (load_valid && !m_done() && !m_err()) begin
                if (n_acc < 4) begin
                    m_len[8*n_acc +: 8] = load_byte;
                end else begin
                    int k;
                    k = n_acc - 4;
                    m_mem[k/4][8*(k%4) +: 8] = load_byte;
                end
                n_acc++;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        vectors++;
        check("instr",       instr,              exp_instr);
        check("instr_valid", 32'(instr_valid),   32'(exp_valid));
        check("load_ready",  32'(load_ready),    32'(!(m_done() || m_err())));
        check("load_done",   32'(load_done),     32'(m_done()));
        check("load_err",    32'(load_err),      32'(m_err()));
    end

    task automatic step();
        @(negedge clk);
        #1;
        if (rand_rd) begin
            case ($urandom_range(0, 7))
                0:       instr_addr = $urandom;
                1, 2:    instr_addr = $urandom_range(0, 32'h5000);
                default: instr_addr = $urandom_range(0, 32'h100);
            endcase
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int g;
        g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        repeat (g) begin
            load_valid = 1'b0;
            load_byte  = 8'($urandom);
            step();
        end
        load_valid = 1'b1;
        load_byte  = b;
        step();
        load_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_max);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap_max);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    // Literal expectations that pin the model as well as the DUT
    task automatic lit(input logic [31:0] a, input logic [31:0] e, input logic ev);
        instr_addr = a;
        @(negedge clk);
        #1;
        vectors++;
        check("lit_instr", instr, e);
        check("lit_valid", 32'(instr_valid), 32'(ev));
    endtask

    task automatic flags(input logic r, input logic d, input logic e);
        vectors++;
        check("lit_ready", 32'(load_ready), 32'(r));
        check("lit_done",  32'(load_done),  32'(d));
        check("lit_err",   32'(load_err),   32'(e));
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        step();

        // Reset state
        lit(32'h0, NOP, 1'b0);
        flags(1'b1, 1'b0, 1'b0);

        // Two-word program with gaps
        send_word(32'h0000_0002, 2);
        send_word(32'h0010_0093, 2);
        send_word(32'h0020_0113, 2);
        step();
        flags(1'b0, 1'b1, 1'b0);
        lit(32'h0,    32'h0010_0093, 1'b1);
        lit(32'h4,    32'h0020_0113, 1'b1);
        lit(32'h8,    NOP,           1'b0);
        lit(32'h6,    32'h0020_0113, 1'b1);
        lit(32'h4000, NOP,           1'b0);

        // Back-to-back random reads
        rand_rd = 1'b1;
        repeat (200) step();
        rand_rd = 1'b0;

        // Bytes after completion are dropped
        for (int i = 0; i < 8; i++) send_byte(8'($urandom), 0);
        flags(1'b0, 1'b1, 1'b0);
        lit(32'h4, 32'h0020_0113, 1'b1);

        // Zero-length program
        do_reset();
        send_word(32'h0, 1);
        flags(1'b0, 1'b1, 1'b0);
        lit(32'h0, NOP, 1'b0);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1);
        flags(1'b0, 1'b1, 1'b0);

        // Oversized length
        do_reset();
        send_word(32'h0000_1001, 1);
        flags(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1);
        lit(32'h0, NOP, 1'b0);
        flags(1'b0, 1'b0, 1'b1);

        // Reset mid-word, then a fresh single-word load; address 0 is
        // held across the final byte so the no-bypass rule is exercised
        do_reset();
        send_word(32'h1, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        do_reset();
        flags(1'b1, 1'b0, 1'b0);
        instr_addr = 32'h0;
        send_word(32'h1, 0);
        send_word(32'hDEAD_BEEF, 0);
        lit(32'h0, 32'hDEAD_BEEF, 1'b1);
        lit(32'h4, NOP, 1'b0);

        // Random programs with random reads throughout
        repeat (6) begin
            int n;
            do_reset();
            n = $urandom_range(1, 48);
            rand_rd = 1'b1;
            send_word(32'(n), 3);
            for (int i = 0; i < 4 * n; i++) send_byte(8'($urandom), 3);
            repeat (100) step();
            rand_rd = 1'b0;
        end

        // Full-depth program
        do_reset();
        rand_rd = 1'b1;
        send_word(32'(DEPTH), 0);
        for (int i = 0; i < 4 * DEPTH; i++) send_byte(8'($urandom), 0);
        repeat (50) step();
        rand_rd = 1'b0;
        flags(1'b0, 1'b1, 1'b0);
        lit(32'h4000, NOP, 1'b0);
        lit(32'hFFFF_FFFC, NOP, 1'b0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
